// File: rtl/result_frame_tx.sv
// Collects up to k search results per query, times the query, and sends them to the host as one
// framed word stream: sync, header, data, cycle count, checksum.
module result_frame_tx #(
    parameter int unsigned K_MAX     = 16,
    parameter logic [31:0] SYNC_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [15:0] k_in,
    input  logic [31:0] result_in,
    input  logic        result_valid_in,
    input  logic        done_in,
    output logic [31:0] tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        busy_out,
    output logic        overflow_out
);

    localparam int unsigned CW = $clog2(K_MAX + 1);
    localparam int unsigned IW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic [2:0] {
        StIdle, StCollect, StSync, StHdr, StData, StCyc, StSum
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  idx_q, idx_d, idx_nxt;
    logic [15:0]    k_eff_q, k_eff_d, k_eff_in, count16;
    logic [31:0]    cyc_q, cyc_d, cyc_inc;
    logic [31:0]    chk_q, chk_d, header;
    logic           ovf_q, ovf_d;
    logic [31:0]    tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic [31:0]    res_buf_q [K_MAX];
    logic           buf_we, hs, term;

    assign k_eff_in = (k_in > 16'(K_MAX)) ? 16'(K_MAX) : k_in;
    assign count16  = 16'(count_q);
    assign header   = {count16, k_eff_q};
    assign cyc_inc  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    assign hs       = tx_valid_q && tx_ready_in;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        idx_nxt    = idx_q + 1'b1;
        k_eff_d    = k_eff_q;
        cyc_d      = cyc_q;
        chk_d      = chk_q;
        ovf_d      = ovf_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        buf_we     = 1'b0;
        term       = 1'b0;
        if (start_in && (state_q == StIdle || state_q == StCollect)) begin
            // Restart from COLLECT behaves exactly like a fresh start; a same-cycle result is lost
            state_d = StCollect;
            count_d = '0;
            k_eff_d = k_eff_in;
            cyc_d   = '0;
            chk_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCollect: begin
                    cyc_d = cyc_inc;
                    if (result_valid_in) begin
                        if (count16 < k_eff_q) begin
                            buf_we  = 1'b1;
                            count_d = count_q + 1'b1;
                            chk_d   = chk_q ^ result_in;
                            if (count16 + 16'd1 == k_eff_q) term = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (done_in || k_eff_q == 16'd0) term = 1'b1;
                    if (term) begin
                        state_d    = StSync;
                        tx_valid_d = 1'b1;
                        tx_data_d  = SYNC_WORD;
                    end
                end
                StSync: if (hs) begin
                    state_d   = StHdr;
                    tx_data_d = header;
                end
                StHdr: if (hs) begin
                    if (count_q == '0) begin
                        state_d   = StCyc;
                        tx_data_d = cyc_q;
                    end else begin
                        state_d   = StData;
                        idx_d     = '0;
                        tx_data_d = res_buf_q[0];
                    end
                end
                StData: if (hs) begin
                    if (idx_nxt == count_q) begin
                        state_d   = StCyc;
                        tx_data_d = cyc_q;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_data_d = res_buf_q[idx_nxt[IW-1:0]];
                    end
                end
                StCyc: if (hs) begin
                    state_d   = StSum;
                    tx_data_d = header ^ chk_q ^ cyc_q;
                end
                StSum: if (hs) begin
                    state_d    = StIdle;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            k_eff_q    <= '0;
            cyc_q      <= '0;
            chk_q      <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            for (int i = 0; i < int'(K_MAX); i++) res_buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            k_eff_q    <= k_eff_d;
            cyc_q      <= cyc_d;
            chk_q      <= chk_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            if (buf_we) res_buf_q[count_q[IW-1:0]] <= result_in;
        end
    end

    assign tx_data_out  = tx_data_q;
    assign tx_valid_out = tx_valid_q;
    assign busy_out     = (state_q != StIdle);
    assign overflow_out = ovf_q;

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
- Host-side transmitter for search results. It is the return direction of the host query frame: sync word, DIM query words, k, vertex id.
- It collects up to k vertex ids from the search engine's top_k_out/valid_out stream for one query and counts the cycles the query takes.
- It then emits one framed 32-bit word stream over a valid/ready link to the host debug/UART bridge.
- It sits between the search engine output and the host interface. It replaces the ad-hoc output FIFO and free-running cycle counter in top level.

Parameters:
K_MAX, 16, result buffer depth; k_in is clamped to this value
SYNC_WORD, 32'hFFFFFFFF, frame start marker (same marker the host uses for query frames)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
start_in  input  1  pulse: query launched to search engine; latch k, clear buffer, start cycle counter
k_in  input  16  requested result count, sampled when start_in is accepted
result_in  input  32  vertex id from search engine
result_valid_in  input  1  result_in valid this cycle (no backpressure to engine)
done_in  input  1  engine finished; ends collection early if fewer than k results arrived
tx_data_out  output  32  frame word to host link
tx_valid_out  output  1  tx_data_out valid
tx_ready_in  input  1  host link accepts word when tx_valid_out && tx_ready_in
busy_out  output  1  high in any state other than IDLE
overflow_out  output  1  sticky per query: a result arrived while the buffer already held k_eff entries

Behaviour:
- Reset (rst_in==0 at a clock edge) puts the block in IDLE and clears every output and internal register. This applies in any state; a frame in progress is aborted, with no partial tail emitted.
- k_eff = min(k_in, K_MAX), latched when start_in is accepted.
- States: IDLE, COLLECT, SYNC, HDR, DATA, CYC, SUM.
- IDLE:
  - start_in moves to COLLECT; clears count, overflow_out and checksum; sets cyc=0.
  - result_valid_in and done_in are ignored.
- COLLECT:
  - cyc increments every cycle and saturates at 32'hFFFFFFFF.
  - result_valid_in with count<k_eff writes buf[count] and increments count.
  - result_valid_in with count==k_eff drops the word and sets overflow_out.
  - Termination happens on the cycle the k_eff-th result is written, or on done_in, whichever comes first; simultaneous result+done stores the result.
  - On termination, cyc is frozen at the value it takes that cycle: cycles elapsed since the start_in edge.
  - If k_eff==0, collection terminates on the cycle after start_in with cyc=1.
  - A start_in pulse during COLLECT restarts the query (as from IDLE); a result in the same cycle is dropped.
- Frame transmission:
  - SYNC is entered on the cycle after termination, so tx_valid_out rises on that cycle.
  - Word order: SYNC_WORD; header = {count[15:0], k_eff[15:0]}; buf[0..count-1]; cyc; checksum.
  - Checksum = XOR of the header, all data words and cyc; SYNC_WORD is excluded.
  - Each state advances only on tx_valid_out && tx_ready_in. tx_data_out and tx_valid_out are registered and held stable while tx_ready_in is low.
  - DATA is skipped when count==0.
  - After the SUM word is accepted, the block returns to IDLE with tx_valid_out low on the next cycle. Back-to-back handshakes give one word per cycle.
- start_in, result_valid_in and done_in are ignored in SYNC through SUM. The engine must not issue a new query while busy_out is high.
- overflow_out is held through transmission and cleared by the next accepted start_in.

Test Plan:
- Normal frame, tx_ready_in=1:
  - Stimulus: reset; start_in at t0 with k_in=2; results 0x11 at t3, 0x22 at t5.
  - Required: from t6 the stream is FFFFFFFF, 00020002, 00000011, 00000022, 00000005, 00020034; busy_out falls after the SUM handshake.
- Backpressure:
  - Stimulus: same query, tx_ready_in toggling 0/1 every cycle.
  - Required: identical word sequence; each word stays stable while tx_ready_in is low.
- Early done:
  - Stimulus: k_in=4; one result 0xAB at t2; done_in at t4.
  - Required: header 00010004, data AB, cyc 4, checksum 00010004^AB^4 = 000100AB.
- Overflow and clamp:
  - Stimulus: k_in=20 (K_MAX=16); 17 results 1..17 on consecutive cycles.
  - Required: header 00100010; data words 1..16; overflow_out=0 through the frame.
  - Stimulus: k_in=2 with results on t1, t2 and a same-cycle result at t2 plus done.
  - Required: no overflow for that case.
  - Stimulus: a third result arriving at termination with done but k reached.
  - Required: the third result is stored only if count<k_eff, otherwise overflow_out=1.
- k_in=0:
  - Stimulus: start_in with k_in=0.
  - Required: frame FFFFFFFF, 00000000, 00000001, 00000001.
- Reset and restart:
  - Stimulus: rst_in low during DATA.
  - Required: next cycle tx_valid_out=0, busy_out=0, and the next query produces a clean frame.
  - Stimulus: start_in re-issued mid-COLLECT.
  - Required: earlier results discarded; cyc counted from the second start.
